// File: rtl/dummy_streamer_pkg.sv
// Shared definitions for the dummy streamer store/load buffer: FSM encoding
// and the storage entry width helper.
package dummy_streamer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_STORE = 2'd0;
  localparam state_t ST_DRAIN = 2'd1;
  localparam state_t ST_LOAD  = 2'd2;

  // One entry holds {TKEEP, TLAST, TDATA}.
  function automatic int entry_width(input int dw);
    return dw + dw / 8 + 1;
  endfunction

endpackage

// File: rtl/streamer_sdp_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// No reset on the array or read register so it maps onto block RAM.
module streamer_sdp_ram #(
  parameter int WIDTH = 37,
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [2**IDX_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register holds its value while re is low; the top relies on this
  // to keep a prefetched entry parked during output back-pressure.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dummy_streamer_store_load.sv
// Half-duplex store-and-forward AXIS packet buffer: captures one TLAST-delimited
// packet, then replays it through a RAM read stage and a registered output.
module dummy_streamer_store_load
  import dummy_streamer_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int STORAGE_IDX_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        S_AXI_TDATA,
  input  logic [DATA_WIDTH/8-1:0]      S_AXI_TKEEP,
  input  logic                         S_AXI_TVALID,
  output logic                         S_AXI_TREADY,
  input  logic                         S_AXI_TLAST,
  output logic [DATA_WIDTH-1:0]        M_AXI_TDATA,
  output logic [DATA_WIDTH/8-1:0]      M_AXI_TKEEP,
  output logic                         M_AXI_TVALID,
  input  logic                         M_AXI_TREADY,
  output logic                         M_AXI_TLAST,
  output logic [STORAGE_IDX_WIDTH:0]   pkt_len,
  output logic                         overflow
);

  localparam int KW    = DATA_WIDTH / 8;
  localparam int EW    = entry_width(DATA_WIDTH);
  localparam int IW    = STORAGE_IDX_WIDTH;
  localparam int LW    = STORAGE_IDX_WIDTH + 1;
  localparam int DEPTH = 2 ** STORAGE_IDX_WIDTH;

  state_t          state_q, state_d;
  logic [IW-1:0]   wptr_q, wptr_d;
  logic [LW-1:0]   rptr_q, rptr_d;
  logic [LW-1:0]   len_q, len_d;
  logic            ovf_q, ovf_d;
  logic            s1_vld_q, s1_vld_d;
  logic            out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [KW-1:0]   out_keep_q, out_keep_d;
  logic            out_last_q, out_last_d;

  logic          s_acc, m_hs, out_ready, rd_en, wr_en, wr_last;
  logic [EW-1:0] ram_rdata;

  assign S_AXI_TREADY = (state_q != ST_LOAD);
  assign s_acc        = S_AXI_TVALID && S_AXI_TREADY;
  assign m_hs         = out_vld_q && M_AXI_TREADY;
  assign out_ready    = !out_vld_q || M_AXI_TREADY;
  assign wr_en        = s_acc && (state_q == ST_STORE);
  // The final slot always closes the packet so replay sees exactly one TLAST.
  assign wr_last      = S_AXI_TLAST || (&wptr_q);
  // Fetch the next entry whenever the read stage is empty or drains this cycle.
  assign rd_en        = (state_q == ST_LOAD) && (!s1_vld_q || out_ready) && (rptr_q < len_q);

  streamer_sdp_ram #(
    .WIDTH (EW),
    .IDX_W (IW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wptr_q),
    .wdata ({S_AXI_TKEEP, wr_last, S_AXI_TDATA}),
    .re    (rd_en),
    .raddr (rptr_q[IW-1:0]),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    len_d      = len_q;
    ovf_d      = ovf_q;
    s1_vld_d   = s1_vld_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_keep_d = out_keep_q;
    out_last_d = out_last_q;

    case (state_q)
      ST_STORE: begin
        if (s_acc) begin
          wptr_d = wptr_q + 1'b1;
          if (S_AXI_TLAST) begin
            len_d   = {1'b0, wptr_q} + LW'(1);
            rptr_d  = '0;
            state_d = ST_LOAD;
          end else if (&wptr_q) begin
            len_d   = LW'(DEPTH);
            ovf_d   = 1'b1;
            rptr_d  = '0;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (s_acc && S_AXI_TLAST) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (m_hs && out_last_q) begin
          wptr_d  = '0;
          state_d = ST_STORE;
        end
      end
      default: state_d = ST_STORE;
    endcase

    if (rd_en)          rptr_d = rptr_q + 1'b1;
    if (rd_en)          s1_vld_d = 1'b1;
    else if (out_ready) s1_vld_d = 1'b0;

    if (out_ready) begin
      out_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        out_data_d = ram_rdata[DATA_WIDTH-1:0];
        out_last_d = ram_rdata[DATA_WIDTH];
        out_keep_d = ram_rdata[EW-1 -: KW];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_STORE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      len_q      <= '0;
      ovf_q      <= 1'b0;
      s1_vld_q   <= 1'b0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_keep_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      len_q      <= len_d;
      ovf_q      <= ovf_d;
      s1_vld_q   <= s1_vld_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_keep_q <= out_keep_d;
      out_last_q <= out_last_d;
    end
  end

  assign M_AXI_TDATA  = out_data_q;
  assign M_AXI_TKEEP  = out_keep_q;
  assign M_AXI_TVALID = out_vld_q;
  assign M_AXI_TLAST  = out_last_q;
  assign pkt_len      = len_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_dummy_streamer_store_load.sv
// Randomized bench for the store/load packet buffer, checked against a
// packet-level model (truncate to DEPTH, sticky overflow, fixed replay latency).
module tb_dummy_streamer_store_load;

  localparam int DW    = 32;
  localparam int KW    = DW / 8;
  localparam int IW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] S_AXI_TDATA;
  logic [KW-1:0] S_AXI_TKEEP;
  logic          S_AXI_TVALID, S_AXI_TREADY, S_AXI_TLAST;
  logic [DW-1:0] M_AXI_TDATA;
  logic [KW-1:0] M_AXI_TKEEP;
  logic          M_AXI_TVALID, M_AXI_TREADY, M_AXI_TLAST;
  logic [IW:0]   pkt_len;
  logic          overflow;

  dummy_streamer_store_load #(
    .DATA_WIDTH        (DW),
    .STORAGE_IDX_WIDTH (IW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .S_AXI_TDATA  (S_AXI_TDATA),
    .S_AXI_TKEEP  (S_AXI_TKEEP),
    .S_AXI_TVALID (S_AXI_TVALID),
    .S_AXI_TREADY (S_AXI_TREADY),
    .S_AXI_TLAST  (S_AXI_TLAST),
    .M_AXI_TDATA  (M_AXI_TDATA),
    .M_AXI_TKEEP  (M_AXI_TKEEP),
    .M_AXI_TVALID (M_AXI_TVALID),
    .M_AXI_TREADY (M_AXI_TREADY),
    .M_AXI_TLAST  (M_AXI_TLAST),
    .pkt_len      (pkt_len),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nerr = 0;
  int nchk = 0;

  logic [DW-1:0] tx_d[$];
  logic [KW-1:0] tx_k[$];
  bit            ovf_exp;
  int            tlast_edge;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_pkt(input bit rnd);
    int n = tx_d.size();
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      forever begin
        @(negedge clk);
        S_AXI_TVALID = rnd ? ($urandom_range(3) != 0) : 1'b1;
        S_AXI_TDATA  = tx_d[i];
        S_AXI_TKEEP  = tx_k[i];
        S_AXI_TLAST  = (i == n - 1);
        if (S_AXI_TVALID && S_AXI_TREADY) break;
        guard++;
        if (guard > 50) begin
          chk("s_ready_timeout", 0, 1);
          S_AXI_TVALID = 1'b0;
          return;
        end
      end
      if (i == n - 1) tlast_edge = cyc + 1;
    end
    @(negedge clk);
    S_AXI_TVALID = 1'b0;
    S_AXI_TLAST  = 1'b0;
    chk("s_ready_low_in_load", S_AXI_TREADY, 0);
    if (n > DEPTH) ovf_exp = 1'b1;
  endtask

  // mode 0: ready held high, 1: ready pattern 1,0,0,1, 2: random ready.
  task automatic recv_pkt(input int mode, input int max_beats);
    int  ne = (tx_d.size() > DEPTH) ? DEPTH : tx_d.size();
    int  idx = 0, guard = 0, ph = 0;
    bit  first = 1, stall = 0, done = 0, r;
    logic [DW-1:0] pd;
    logic [KW-1:0] pk;
    logic          pl;
    while (!done) begin
      @(negedge clk);
      if (M_AXI_TVALID && first) begin
        chk("first_valid_latency", cyc - tlast_edge, 2);
        first = 0;
      end
      chk("s_ready_low_replay", S_AXI_TREADY, 0);
      if (stall) begin
        chk("stall_data", M_AXI_TDATA, pd);
        chk("stall_keep", M_AXI_TKEEP, pk);
        chk("stall_last", M_AXI_TLAST, pl);
        chk("stall_valid", M_AXI_TVALID, 1);
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = (ph % 4 == 0) || (ph % 4 == 3);
        default: r = 1'($urandom_range(1));
      endcase
      if (M_AXI_TVALID) ph++;
      M_AXI_TREADY = r;
      stall = M_AXI_TVALID && !r;
      pd = M_AXI_TDATA; pk = M_AXI_TKEEP; pl = M_AXI_TLAST;
      if (M_AXI_TVALID && r) begin
        if (idx < ne) begin
          chk("out_data", M_AXI_TDATA, tx_d[idx]);
          chk("out_keep", M_AXI_TKEEP, tx_k[idx]);
          chk("out_last", M_AXI_TLAST, (idx == ne - 1));
        end else begin
          chk("extra_beat", 1, 0);
        end
        idx++;
        if (M_AXI_TLAST || idx == max_beats || idx > ne) done = 1;
      end
      guard++;
      if (guard > 300) begin
        chk("recv_timeout", 0, 1);
        done = 1;
      end
    end
    if (idx != max_beats) begin
      chk("beat_count", idx, ne);
      @(negedge clk);
      chk("valid_drop_after_last", M_AXI_TVALID, 0);
      chk("s_ready_back", S_AXI_TREADY, 1);
      chk("pkt_len", pkt_len, ne);
      chk("overflow", overflow, ovf_exp);
    end
    M_AXI_TREADY = 1'b1;
  endtask

  task automatic fill_rand(input int n);
    tx_d.delete(); tx_k.delete();
    for (int i = 0; i < n; i++) begin
      tx_d.push_back($urandom);
      tx_k.push_back(KW'($urandom_range(15, 1)));
    end
  endtask

  task automatic fill_inc(input int n);
    tx_d.delete(); tx_k.delete();
    for (int i = 0; i < n; i++) begin
      tx_d.push_back(DW'((i + 1) * 32'h11));
      tx_k.push_back(4'hF);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_m_valid"}, M_AXI_TVALID, 0);
    chk({tag, "_m_last"},  M_AXI_TLAST, 0);
    chk({tag, "_m_data"},  M_AXI_TDATA, 0);
    chk({tag, "_m_keep"},  M_AXI_TKEEP, 0);
    chk({tag, "_pkt_len"}, pkt_len, 0);
    chk({tag, "_overflow"}, overflow, 0);
  endtask

  initial begin
    reset = 1'b0;
    S_AXI_TDATA = '0; S_AXI_TKEEP = '0; S_AXI_TVALID = 1'b0; S_AXI_TLAST = 1'b0;
    M_AXI_TREADY = 1'b1;
    ovf_exp = 1'b0;
    tlast_edge = 0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) reset = 1'b1;
    @(negedge clk) chk("s_ready_after_reset", S_AXI_TREADY, 1);

    fill_inc(4);            send_pkt(0); recv_pkt(0, -1);
    fill_inc(4);            send_pkt(0); recv_pkt(1, -1);
    tx_d.delete(); tx_k.delete();
    tx_d.push_back(32'hDEADBEEF); tx_k.push_back(4'h3);
    send_pkt(0); recv_pkt(0, -1);
    fill_rand(DEPTH);       send_pkt(0); recv_pkt(2, -1);
    fill_rand(10);          send_pkt(0); recv_pkt(0, -1);
    for (int p = 0; p < 8; p++) begin
      fill_rand($urandom_range(12, 1));
      send_pkt(1);
      recv_pkt(2, -1);
    end

    // Reset while replay is mid-packet.
    fill_inc(4); send_pkt(0); recv_pkt(0, 2);
    @(posedge clk);
    #2 reset = 1'b0;
    ovf_exp = 1'b0;
    #1 check_reset_outputs("midload_reset");
    @(negedge clk) reset = 1'b1;
    @(negedge clk) chk("s_ready_after_midload_reset", S_AXI_TREADY, 1);
    fill_rand(3); send_pkt(1); recv_pkt(2, -1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/dummy_streamer_store_load.md
Name: dummy_streamer_store_load

Overview:
- Store-and-forward packet buffer that sits directly downstream of the dummy pass-through streamer and consumes its AXIS master output.
- Captures one full AXIS packet, delimited by TLAST, into internal storage. It then replays that packet unchanged on its own AXIS master.
- Used to model a reconfigurable-partition payload that must hold a whole frame before emitting it, e.g. for DFX sequencer test traffic.

Parameters:
- DATA_WIDTH, 32, AXIS data width in bits; must be a multiple of 8.
- STORAGE_IDX_WIDTH, 10, storage address width; depth DEPTH = 2**STORAGE_IDX_WIDTH beats.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- S_AXI_TDATA  in  DATA_WIDTH  store-side data.
- S_AXI_TKEEP  in  DATA_WIDTH/8  store-side byte keep.
- S_AXI_TVALID  in  1  store-side valid.
- S_AXI_TREADY  out  1  store-side ready.
- S_AXI_TLAST  in  1  store-side end of packet.
- M_AXI_TDATA  out  DATA_WIDTH  replay data.
- M_AXI_TKEEP  out  DATA_WIDTH/8  replay byte keep.
- M_AXI_TVALID  out  1  replay valid.
- M_AXI_TREADY  in  1  replay ready.
- M_AXI_TLAST  out  1  replay end of packet.
- pkt_len  out  STORAGE_IDX_WIDTH+1  beat count of the packet currently held (1..DEPTH).
- overflow  out  1  sticky flag: a packet exceeded DEPTH and was truncated.

Behaviour:
- Reset (reset=0, asynchronous):
  - Go to state STORE with write pointer 0.
  - M_AXI_TVALID, M_AXI_TLAST, M_AXI_TDATA, M_AXI_TKEEP, pkt_len and overflow all reset to 0.
  - Reset mid-packet discards all stored data and clears overflow.
- Storage:
  - DEPTH entries of {TKEEP, TLAST, TDATA}.
  - Synchronous write; registered read with 1-cycle latency.
- A transfer happens on any interface only when VALID and READY are both 1 on a rising edge.
- STORE state:
  - S_AXI_TREADY = 1; M_AXI_TVALID = 0.
  - Each accepted beat is written at wptr, and wptr increments.
  - Accepted beat with TLAST=1 and wptr < DEPTH-1:
    - Store it with last=1; pkt_len <= wptr+1.
    - Next state LOAD.
  - Accepted beat at wptr == DEPTH-1 with TLAST=0:
    - Store it with last forced to 1; pkt_len <= DEPTH; overflow <= 1.
    - Next state DRAIN.
  - Accepted beat at wptr == DEPTH-1 with TLAST=1: normal end of packet, pkt_len = DEPTH, no overflow.
- DRAIN state:
  - S_AXI_TREADY = 1; beats are accepted and discarded.
  - The beat with TLAST=1 moves the block to LOAD.
- LOAD state:
  - S_AXI_TREADY = 0.
  - The read pointer starts at 0. The first M_AXI_TVALID rises exactly 2 cycles after the store-side TLAST handshake (1 cycle for the state change, 1 cycle for the registered read).
  - Output is a registered skid: M_AXI_* hold stable while M_AXI_TVALID=1 and M_AXI_TREADY=0.
  - Next entry is prefetched so that with M_AXI_TREADY held at 1 one beat transfers every cycle after the first.
  - M_AXI_TLAST = stored last bit; exactly one TLAST per packet.
  - Handshake of the TLAST beat:
    - M_AXI_TVALID deasserts in the next cycle unless a new beat is presented.
    - wptr <= 0; next state STORE.
    - S_AXI_TREADY returns to 1 in the cycle after that handshake.
- Simultaneous events: store and load never overlap, so there is no read/write collision. This is a half-duplex buffer.
- Zero-length packets cannot occur because TLAST always rides on a data beat; minimum pkt_len = 1.
- pkt_len holds its value through LOAD and the following STORE until the next packet completes.
- overflow clears only on reset.
- TDATA and TKEEP pass through unmodified; no byte manipulation.

Decomposition:
- Shared package dummy_streamer_pkg:
  - State encoding ST_STORE=2'd0, ST_DRAIN=2'd1, ST_LOAD=2'd2.
  - Helper for the entry width (DATA_WIDTH + DATA_WIDTH/8 + 1).
- Sub-module streamer_sdp_ram:
  - Simple dual-port RAM, one write port and one registered read port, parameterised by width and STORAGE_IDX_WIDTH.
  - Infers block RAM.
- Top level contains the FSM, pointers and output register.

Test Plan:
- Single packet, ready always 1:
  - Send 4 beats 0x11..0x44, TKEEP=0xF, TLAST on beat 4.
  - Expect M_AXI beats 0x11..0x44 in order, TLAST only on 0x44, first M_AXI_TVALID 2 cycles after the input TLAST.
  - Expect pkt_len = 4 and overflow = 0.
- Back-pressure:
  - Same packet with M_AXI_TREADY toggling 1,0,0,1.
  - Expect M_AXI_TDATA/TKEEP/TLAST stable while stalled, no beat lost or duplicated, S_AXI_TREADY = 0 throughout replay.
- Single-beat packet:
  - One beat 0xDEADBEEF with TLAST=1 and TKEEP=0x3.
  - Expect one output beat with TLAST=1 and TKEEP=0x3; pkt_len = 1.
- Overflow:
  - STORAGE_IDX_WIDTH=3, send a 10-beat packet.
  - Expect 8 beats replayed, TLAST on the 8th, beats 9–10 discarded, overflow = 1, pkt_len = 8.
- Exact fit:
  - STORAGE_IDX_WIDTH=3, send 8 beats with TLAST on the 8th.
  - Expect overflow = 0 and pkt_len = 8.
- Reset mid-load:
  - Assert reset after 2 of 4 beats have been replayed.
  - Expect all outputs 0 immediately; after release, S_AXI_TREADY = 1 and a new 3-beat packet replays correctly.
